// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the ID/EX register, seq_alu and EX/MEM.
// master drives operands and out_ready; slave returns in_ready and results.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] val_1;
  logic [WIDTH-1:0] val_2;
  logic [3:0]       exec_cmd;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       status_bits;

  modport master (
    output in_valid, val_1, val_2, exec_cmd, cin, out_ready,
    input  in_ready, out_valid, alu_res, status_bits
  );

  modport slave (
    input  in_valid, val_1, val_2, exec_cmd, cin, out_ready,
    output in_ready, out_valid, alu_res, status_bits
  );
endinterface

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready handshakes and {Z,C,N,V} status.
// Define ALU_MUL_EN to add the iterative radix-2 shift-add multiply (cmd 1010).
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  seq_alu_if.slave  bus
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MUL = 4'b1010
  } cmd_t;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       status_q;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic             c_flag;
  logic             v_flag;

  function automatic logic [3:0] flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r == '0, c, r[WIDTH-1], v};
  endfunction

  assign in_ready        = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept          = bus.in_valid & in_ready;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_res     = res_q;
  assign bus.status_bits = status_q;

  // Borrow lands in sum[WIDTH] for SUB/SBC, so C is its inverse.
  always_comb begin
    res    = '0;
    sum    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (bus.exec_cmd)
      CMD_MOV: res = bus.val_2;
      CMD_MVN: res = ~bus.val_2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, bus.val_1} + {1'b0, bus.val_2}
            + ((bus.exec_cmd == CMD_ADC) ? {{WIDTH{1'b0}}, bus.cin} : '0);
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (bus.val_1[WIDTH-1] == bus.val_2[WIDTH-1]) && (res[WIDTH-1] != bus.val_1[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, bus.val_1} - {1'b0, bus.val_2}
            - ((bus.exec_cmd == CMD_SBC) ? {{WIDTH{1'b0}}, bus.cin} : '0);
        res    = sum[WIDTH-1:0];
        c_flag = ~sum[WIDTH];
        v_flag = (bus.val_1[WIDTH-1] != bus.val_2[WIDTH-1]) && (res[WIDTH-1] != bus.val_1[WIDTH-1]);
      end
      CMD_AND: res = bus.val_1 & bus.val_2;
      CMD_ORR: res = bus.val_1 | bus.val_2;
      CMD_EOR: res = bus.val_1 ^ bus.val_2;
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] counter;
  logic             is_mul;

  assign is_mul   = (bus.exec_cmd == CMD_MUL);
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      status_q    <= '0;
`ifdef ALU_MUL_EN
      counter     <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
              state       <= BUSY;
              out_valid_q <= 1'b0;
              acc         <= '0;
              mcand       <= bus.val_1;
              mplier      <= bus.val_2;
              counter     <= '0;
            end else
`endif
            begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              res_q       <= res;
              status_q    <= flags(res, c_flag, v_flag);
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        // One multiplier bit per cycle; the last iteration writes the result directly.
        BUSY: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CNT_W'(1);
          if (counter == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= acc_next;
            status_q    <= flags(acc_next, 1'b0, 1'b0);
            counter     <= '0;
          end
        end
`endif
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); MUL checks follow ALU_MUL_EN.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.exec_cmd = cmd;
    bus.val_1    = a;
    bus.val_2    = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] r, input logic [3:0] s);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_res"}, bus.alu_res, r);
    chk({tag, "_zcnv"}, bus.status_bits, s);
  endtask

  initial begin
    int  n;
    logic stale;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.val_1     = '0;
    bus.val_2     = '0;
    bus.exec_cmd  = 4'b0000;
    bus.cin       = 1'b0;

    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_res", bus.alu_res, 0);
    chk("rst_status", bus.status_bits, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b1;
    step();

    bus.out_ready = 1'b1;
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    expect_res("add_ovf", 32'h8000_0000, 4'b0011);
    send(4'b0100, 32'd5, 32'd5, 1'b0);
    expect_res("sub_zero", 32'd0, 4'b1100);
    send(4'b0100, 32'd3, 32'd5, 1'b0);
    expect_res("sub_borrow", 32'hFFFF_FFFE, 4'b0010);
    send(4'b0101, 32'd5, 32'd4, 1'b1);
    expect_res("sbc_zero", 32'd0, 4'b1100);
    send(4'b0100, 32'h8000_0000, 32'd1, 1'b0);
    expect_res("sub_ovf", 32'h7FFF_FFFF, 4'b0101);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    expect_res("add_carry", 32'd0, 4'b1100);
    send(4'b0001, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    expect_res("mov", 32'h0000_1234, 4'b0000);
    send(4'b1001, 32'h0, 32'h0, 1'b0);
    expect_res("mvn", 32'hFFFF_FFFF, 4'b0010);
    send(4'b0110, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);
    expect_res("and", 32'h0000_00F0, 4'b0000);
    send(4'b0111, 32'h0000_F000, 32'h0000_000F, 1'b0);
    expect_res("orr", 32'h0000_F00F, 4'b0000);
    send(4'b1000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
    expect_res("eor_zero", 32'd0, 4'b1000);
    send(4'b1111, 32'd7, 32'd9, 1'b1);
    expect_res("undef_cmd", 32'd0, 4'b1000);
    step();
    chk("consumed_out_valid", bus.out_valid, 0);

    // Backpressure: result held, source holds the next op until out_ready rises.
    bus.out_ready = 1'b0;
    send(4'b0011, 32'd1, 32'd1, 1'b1);
    bus.exec_cmd = 4'b1000;
    bus.val_1    = 32'h0000_F0F0;
    bus.val_2    = 32'h0000_FFFF;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_res("adc_hold", 32'd3, 4'b0000);
      chk("hold_in_ready", bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    expect_res("b2b_eor", 32'h0000_0F0F, 4'b0000);

`ifdef ALU_MUL_EN
    send(4'b1010, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      chk("busy_in_ready", bus.in_ready, 0);
      step();
      n++;
    end
    chk("mul_latency", n, 33);
    expect_res("mul_big", 32'hFFFF_FFFF, 4'b0010);
    send(4'b1010, 32'h0001_0000, 32'h0001_0000, 1'b0);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      step();
      n++;
    end
    expect_res("mul_wrap", 32'd0, 4'b1000);

    // Reset during an in-flight multiply: nothing may emerge afterwards.
    send(4'b1010, 32'd7, 32'd9, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    #1;
    chk("midmul_rst_valid", bus.out_valid, 0);
    chk("midmul_rst_res", bus.alu_res, 0);
    chk("midmul_rst_status", bus.status_bits, 0);
    rst = 1'b1;
    #1;
    chk("midmul_rst_in_ready", bus.in_ready, 1);
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) stale = 1'b1;
    end
    chk("midmul_no_stale", stale, 0);
    send(4'b1010, 32'd7, 32'd9, 1'b0);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      step();
      n++;
    end
    chk("mul_7x9_latency", n, 33);
    expect_res("mul_7x9", 32'd63, 4'b0000);
`else
    send(4'b1010, 32'd3, 32'd4, 1'b0);
    expect_res("mul_disabled", 32'd0, 4'b1000);
    step();
    chk("mul_disabled_consumed", bus.out_valid, 0);

    // Reset while a result is held under backpressure.
    bus.out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd2, 1'b0);
    expect_res("held_add", 32'd3, 4'b0000);
    step();
    rst = 1'b0;
    #1;
    chk("held_rst_valid", bus.out_valid, 0);
    chk("held_rst_res", bus.alu_res, 0);
    chk("held_rst_status", bus.status_bits, 0);
    rst = 1'b1;
    #1;
    chk("held_rst_in_ready", bus.in_ready, 1);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid) stale = 1'b1;
    end
    chk("held_no_stale", stale, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
